coprocessor0_irq: RTL
=====================

Name: coprocessor0_irq

Overview:
- Parametrised CP0 for the MIPS core. Replaces the Status/Cause/EPC-only CP0.
- Adds BadVAddr, a Count/Compare timer, sampled hardware interrupt lines, an interrupt-request output and a flush/redirect target to IF.
- Sits beside the WB stage: takes exception, ERET and MTC0 events from WB; serves MFC0 reads combinationally.

Parameters:
HW_INT_COUNT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2 +: HW_INT_COUNT]
COUNT_DIVIDE, 2, core cycles per Count increment (power of two, >=1)
EXCEPTION_VECTOR, 32'hBFC0_0380, redirect address on exception
DATA_WIDTH, 32, register/data width

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
hw_interrupt  in  HW_INT_COUNT  level-sensitive external interrupt lines
write_enabled  in  1  MTC0 commit from WB
write_register  in  5  MTC0 rd
write_select  in  3  MTC0 sel
write_data  in  DATA_WIDTH  MTC0 value
read_register  in  5  MFC0 rd
read_select  in  3  MFC0 sel
read_data  out  DATA_WIDTH  MFC0 value, combinational
exception_valid  in  1  WB commits an exception
exception_code  in  5  ExcCode
exception_pc  in  DATA_WIDTH  PC of faulting instruction
exception_bad_vaddr  in  DATA_WIDTH  faulting address for AdEL/AdES
in_delay_slot  in  1  faulting instruction is in a delay slot
eret_valid  in  1  WB commits ERET
interrupt_pending  out  1  interrupt request to ID/WB
flush_valid  out  1  redirect IF this cycle
flush_target  out  DATA_WIDTH  redirect address

Behaviour:
- Implemented registers (sel 0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. All other reads return 0; other writes are ignored.
- Reset values:
  - Status = 32'h0040_0000: BEV=1, IM=0, EXL=0, IE=0.
  - Cause = 0; EPC = 0; BadVAddr = 0; Count = 0; Compare = 32'hFFFF_FFFF; divider = 0.
  - Outputs after reset: interrupt_pending=0, flush_valid=0.
- Update priority per register in one cycle: reset > exception_valid > eret_valid > MTC0 write.
- Status:
  - Writable fields: IM[15:8], EXL[1], IE[0]. BEV is read-only 1; all other bits read 0.
  - Exception sets EXL. ERET clears EXL.
- Cause:
  - IP[1:0] (bits 9:8) writable by MTC0.
  - IP[7:2] are registered copies of hw_interrupt, resampled every cycle, with one cycle of latency; bits above HW_INT_COUNT read 0.
  - IP7 (bit 15) = sampled line 5 (if present) OR TI.
  - TI (bit 30) is read-only.
  - BD (bit 31) and ExcCode (bits 6:2) load on exception. BD loads only when EXL=0; ExcCode always loads.
- EPC:
  - On exception with EXL=0: EPC <= in_delay_slot ? exception_pc-4 : exception_pc. With EXL=1, EPC holds.
  - Otherwise EPC is MTC0-writable.
- BadVAddr:
  - Loads exception_bad_vaddr on exception with ExcCode 4 or 5; read-only to MTC0.
- Count:
  - A divider counter wraps at COUNT_DIVIDE-1. On the wrap cycle Count increments by 1, modulo 2^32, wrapping FFFF_FFFF->0.
  - MTC0 to Count loads write_data and resets the divider; the write wins over the increment.
- Timer interrupt:
  - TI sets on a cycle where Count increments to a value equal to Compare.
  - MTC0 to Compare clears TI; clear wins over a same-cycle set.
- interrupt_pending = IE & ~EXL & |(Cause.IP & Status.IM), combinational from registers.
- Flush:
  - flush_valid = exception_valid | eret_valid, combinational.
  - flush_target = EXCEPTION_VECTOR if exception_valid, else the current, pre-update EPC.
- Reset asserted mid-operation discards any same-cycle exception, ERET or write.

Optional Feature:
COPROCESSOR0_TIMER_EN
- Defined: Count, Compare and TI behave as above.
- Undefined: no timer logic. Count and Compare read 0, writes to them are ignored, TI is constant 0.

Decomposition:
- Shared package coprocessor0_params holds:
  - StatusData and CauseData packed structs.
  - Register-number constants: REG_BADVADDR, REG_COUNT, REG_COMPARE, REG_STATUS, REG_CAUSE, REG_EPC.
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
- One sub-module, coprocessor0_timer, holds the divider, Count, Compare and TI. It is instantiated only under COPROCESSOR0_TIMER_EN.

Test Plan:
- Reset, then read 12/13/14 -> 32'h0040_0000 / 0 / 0; interrupt_pending=0.
- Exception, code 4, pc 32'hBFC0_0100, bad_vaddr 32'h0000_0003, in_delay_slot=1 -> EPC=32'hBFC0_00FC, BadVAddr=32'h3, Cause=32'h8000_0010, EXL=1, flush_target=32'hBFC0_0380. Second exception while EXL=1 -> EPC and BD unchanged.
- ERET with EPC=32'h8000_1234 -> flush_valid=1, flush_target=32'h8000_1234, EXL=0 next cycle.
- Write Status=32'h0000_0401, pulse hw_interrupt[0] -> Cause.IP2=1 one cycle later; interrupt_pending=1 that cycle; 0 after the line drops plus one cycle.
- Write Count=10, Compare=12, IM7 and IE set -> TI=1 after 4 cycles at COUNT_DIVIDE=2; interrupt_pending=1; write Compare -> TI=0.
- Same cycle: exception plus MTC0 to Status clearing EXL -> EXL=1. Count=FFFF_FFFF increments -> 0 without a timer interrupt when Compare≠0.

Source files
------------

// File: rtl/coprocessor0_irq_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and the
// architectural bit layouts of Status and Cause.
package coprocessor0_params;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } ExcCode;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] im;
        logic [5:0] zero_7_2;
        logic       exl;
        logic       ie;
    } StatusData;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [7:0]  ip;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } CauseData;

endpackage

// File: rtl/coprocessor0_irq_timer.sv
// Count/Compare timer: prescaled Count, Compare match raises TI until
// Compare is rewritten.
module coprocessor0_timer #(
    parameter int COUNT_DIVIDE = 2,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  count_write,
    input  logic                  compare_write,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] count_value,
    output logic [DATA_WIDTH-1:0] compare_value,
    output logic                  timer_interrupt
);

    localparam int DIV_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIVIDE - 1);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic                  ti_q, ti_d;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_write) begin
            count_d = write_data;
            div_d   = '0;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + DATA_WIDTH'(1);
            if (count_d == compare_q) ti_d = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        // Compare write acknowledges the interrupt, beating a same-cycle match.
        if (compare_write) begin
            compare_d = write_data;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '1;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_value     = count_q;
    assign compare_value   = compare_q;
    assign timer_interrupt = ti_q;

endmodule

// File: rtl/coprocessor0_irq.sv
// CP0 with BadVAddr, sampled hardware interrupts, IRQ request and IF redirect.
// Define COPROCESSOR0_TIMER_EN to include the Count/Compare timer.
module coprocessor0_irq
    import coprocessor0_params::*;
#(
    parameter int                    HW_INT_COUNT     = 6,
    parameter int                    COUNT_DIVIDE     = 2,
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] EXCEPTION_VECTOR = 32'hBFC0_0380
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [HW_INT_COUNT-1:0] hw_interrupt,
    input  logic                    write_enabled,
    input  logic [4:0]              write_register,
    input  logic [2:0]              write_select,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [4:0]              read_register,
    input  logic [2:0]              read_select,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    exception_valid,
    input  logic [4:0]              exception_code,
    input  logic [DATA_WIDTH-1:0]   exception_pc,
    input  logic [DATA_WIDTH-1:0]   exception_bad_vaddr,
    input  logic                    in_delay_slot,
    input  logic                    eret_valid,
    output logic                    interrupt_pending,
    output logic                    flush_valid,
    output logic [DATA_WIDTH-1:0]   flush_target
);

    logic [7:0]              im_q, im_d;
    logic                    exl_q, exl_d;
    logic                    ie_q, ie_d;
    logic                    bd_q, bd_d;
    logic [4:0]              exc_code_q, exc_code_d;
    logic [1:0]              ip_sw_q, ip_sw_d;
    logic [HW_INT_COUNT-1:0] hw_q, hw_d;
    logic [DATA_WIDTH-1:0]   epc_q, epc_d;
    logic [DATA_WIDTH-1:0]   badvaddr_q, badvaddr_d;

    logic                  wr_sel0, wr_status, wr_cause, wr_epc;
    logic                  ti;
    logic [DATA_WIDTH-1:0] count_value, compare_value;
    logic [7:0]            ip;
    StatusData             status_view;
    CauseData              cause_view;

    assign wr_sel0   = write_enabled && (write_select == 3'd0);
    assign wr_status = wr_sel0 && (write_register == REG_STATUS);
    assign wr_cause  = wr_sel0 && (write_register == REG_CAUSE);
    assign wr_epc    = wr_sel0 && (write_register == REG_EPC);

`ifdef COPROCESSOR0_TIMER_EN
    logic wr_count, wr_compare;

    assign wr_count   = wr_sel0 && (write_register == REG_COUNT);
    assign wr_compare = wr_sel0 && (write_register == REG_COMPARE);

    coprocessor0_timer #(
        .COUNT_DIVIDE (COUNT_DIVIDE),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_timer (
        .clock           (clock),
        .reset           (reset),
        .count_write     (wr_count),
        .compare_write   (wr_compare),
        .write_data      (write_data),
        .count_value     (count_value),
        .compare_value   (compare_value),
        .timer_interrupt (ti)
    );
`else
    assign ti            = 1'b0;
    assign count_value   = '0;
    assign compare_value = '0;
`endif

    // An exception owns Status/Cause/EPC for its cycle; ERET only owns Status.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        hw_d       = hw_interrupt;
        if (exception_valid) begin
            exl_d      = 1'b1;
            exc_code_d = exception_code;
            if (!exl_q) begin
                bd_d  = in_delay_slot;
                epc_d = in_delay_slot ? exception_pc - DATA_WIDTH'(4) : exception_pc;
            end
            if (exception_code == EXC_ADEL || exception_code == EXC_ADES)
                badvaddr_d = exception_bad_vaddr;
        end else begin
            if (eret_valid) begin
                exl_d = 1'b0;
            end else if (wr_status) begin
                im_d  = write_data[15:8];
                exl_d = write_data[1];
                ie_d  = write_data[0];
            end
            if (wr_cause) ip_sw_d = write_data[9:8];
            if (wr_epc)   epc_d   = write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            hw_q       <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            hw_q       <= hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        ip                    = '0;
        ip[1:0]               = ip_sw_q;
        ip[2 +: HW_INT_COUNT] = hw_q;
        ip[7]                 = ip[7] | ti;

        status_view     = '0;
        status_view.bev = 1'b1;
        status_view.im  = im_q;
        status_view.exl = exl_q;
        status_view.ie  = ie_q;

        cause_view          = '0;
        cause_view.bd       = bd_q;
        cause_view.ti       = ti;
        cause_view.ip       = ip;
        cause_view.exc_code = exc_code_q;
    end

    always_comb begin
        read_data = '0;
        if (read_select == 3'd0) begin
            case (read_register)
                REG_BADVADDR: read_data = badvaddr_q;
                REG_COUNT:    read_data = count_value;
                REG_COMPARE:  read_data = compare_value;
                REG_STATUS:   read_data = DATA_WIDTH'(status_view);
                REG_CAUSE:    read_data = DATA_WIDTH'(cause_view);
                REG_EPC:      read_data = epc_q;
                default:      read_data = '0;
            endcase
        end
    end

    assign interrupt_pending = ie_q & ~exl_q & (|(ip & im_q));
    assign flush_valid       = exception_valid | eret_valid;
    assign flush_target      = exception_valid ? EXCEPTION_VECTOR : epc_q;

endmodule
